// File: rtl/reg_skid_pkg.sv
// reg_skid_pkg
// Shared types for the reg_skid elastic pipeline register.
//   skid_state_e : occupancy of the two-entry buffer (2'd3 is illegal and
//                  recovers to S_EMPTY).
package reg_skid_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } skid_state_e;

endpackage : reg_skid_pkg

// File: rtl/reg_en_arst.sv
// reg_en_arst
// DWIDTH-wide data register with load enable and asynchronous active-low
// reset to zero.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous reset, active low
//   en  : load enable
//   d   : next value, captured when en=1
//   q   : registered value
module reg_en_arst #(
   parameter int unsigned DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DWIDTH-1:0] d,
   output logic [DWIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule : reg_en_arst

// File: rtl/reg_skid.sv
// reg_skid
// Two-entry elastic pipeline register (skid buffer). The upstream side sees
// in_ready_o decoded purely from registered state, so there is no
// combinational path from out_ready_i back to in_ready_o. One transfer per
// cycle, one cycle of latency, strict FIFO order.
//
// Optional build macro: REG_SKID_STALL_CNT_EN adds stall_cnt_o, a saturating
// count of cycles where out_valid_o=1 and out_ready_i=0 (cleared by reset).
//
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous reset, active low
//   in_valid_i  : upstream word valid
//   in_data_i   : upstream payload
//   in_ready_o  : buffer can accept a word this cycle
//   out_valid_o : out_data_o holds a valid word
//   out_data_o  : downstream payload (main register)
//   out_ready_i : downstream takes the word this cycle
//   stall_cnt_o : saturating stall counter (REG_SKID_STALL_CNT_EN only)
//
// state   | meaning
// S_EMPTY | nothing buffered, output invalid
// S_ONE   | one word in main, skid unused
// S_FULL  | main holds the head word, skid holds the next; input blocked
module reg_skid
   import reg_skid_pkg::*;
#(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   input  logic [DWIDTH-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              out_valid_o,
   output logic [DWIDTH-1:0] out_data_o,
   input  logic              out_ready_i
`ifdef REG_SKID_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

   skid_state_e       state_q;
   skid_state_e       state_d;
   logic              main_en;
   logic              skid_en;
   logic              main_sel_skid;
   logic [DWIDTH-1:0] main_d;
   logic [DWIDTH-1:0] main_q;
   logic [DWIDTH-1:0] skid_q;
   logic              in_fire;
   logic              out_fire;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Decoded from the state register only; rst gates it low during reset
   // because the reset state (S_EMPTY) would otherwise read as ready.
   assign in_ready_o  = rst & ((state_q == S_EMPTY) | (state_q == S_ONE));
   assign out_valid_o = (state_q == S_ONE) | (state_q == S_FULL);
   assign out_data_o  = main_q;

   assign in_fire  = in_valid_i & in_ready_o;
   assign out_fire = out_valid_o & out_ready_i;

   always_comb begin
      state_d       = state_q;
      main_en       = 1'b0;
      skid_en       = 1'b0;
      main_sel_skid = 1'b0;
      case (state_q)
         S_EMPTY: begin
            if (in_fire) begin
               main_en = 1'b1;
               state_d = S_ONE;
            end
         end
         S_ONE: begin
            if (in_fire && out_fire) begin
               main_en = 1'b1;
            end else if (in_fire) begin
               skid_en = 1'b1;
               state_d = S_FULL;
            end else if (out_fire) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            if (out_fire) begin
               main_en       = 1'b1;
               main_sel_skid = 1'b1;
               state_d       = S_ONE;
            end
         end
         default: begin
            state_d = S_EMPTY;
         end
      endcase
   end

   assign main_d = main_sel_skid ? skid_q : in_data_i;

   reg_en_arst #(.DWIDTH(DWIDTH)) u_main (
      .clk (clk),
      .rst (rst),
      .en  (main_en),
      .d   (main_d),
      .q   (main_q)
   );

   // Skid contents only matter in S_FULL, so it is never cleared on drain.
   reg_en_arst #(.DWIDTH(DWIDTH)) u_skid (
      .clk (clk),
      .rst (rst),
      .en  (skid_en),
      .d   (in_data_i),
      .q   (skid_q)
   );

`ifdef REG_SKID_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else if (out_valid_o && !out_ready_i && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule : reg_skid

// File: tb/tb_reg_skid.sv
module tb_reg_skid;

   localparam int DWIDTH = 32;
   localparam int CNT_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid_i = 1'b0;
   logic [DWIDTH-1:0] in_data_i = '0;
   logic              in_ready_o;
   logic              out_valid_o;
   logic [DWIDTH-1:0] out_data_o;
   logic              out_ready_i = 1'b0;
`ifdef REG_SKID_STALL_CNT_EN
   logic [CNT_W-1:0]  stall_cnt_o;
`endif

   reg_skid #(.DWIDTH(DWIDTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid_i),
      .in_data_i   (in_data_i),
      .in_ready_o  (in_ready_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_ready_i (out_ready_i)
`ifdef REG_SKID_STALL_CNT_EN
      ,
      .stall_cnt_o (stall_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] id;
      logic        ordy;
      logic        eir;
      logic        eov;
      logic [31:0] eod;
   } vec_t;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] model_q[$];
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data  = '0;
   int          model_stall = 0;
   logic        s_ir;
   logic        s_ov;
   logic [31:0] s_od;
   logic        last_in_fire;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      model_q.delete();
      prev_stall  = 1'b0;
      model_stall = 0;
   endtask

   // One clock cycle: drive after the edge, sample and check on the falling
   // edge, then advance the reference model to the next rising edge.
   task automatic step(input logic iv, input logic [31:0] id, input logic ordy);
      int sz;
      @(posedge clk);
      #1;
      in_valid_i  = iv;
      in_data_i   = id;
      out_ready_i = ordy;
      @(negedge clk);
      s_ir = in_ready_o;
      s_ov = out_valid_o;
      s_od = out_data_o;
      sz   = model_q.size();
      check("in_ready", 32'(s_ir), 32'(rst && (sz < 2)));
      check("out_valid", 32'(s_ov), 32'(sz > 0));
      if (sz > 0) check("sb_data", s_od, model_q[0]);
      if (prev_stall) check("stall_hold", s_od, prev_data);
`ifdef REG_SKID_STALL_CNT_EN
      check("stall_cnt", 32'(stall_cnt_o), 32'(model_stall));
      if (sz > 0 && !ordy && model_stall < CNT_MAX) model_stall++;
`endif
      prev_stall   = (sz > 0) && !ordy;
      prev_data    = s_od;
      last_in_fire = iv && (sz < 2);
      if (sz > 0 && ordy) void'(model_q.pop_front());
      if (last_in_fire) model_q.push_back(id);
   endtask

   vec_t        vecs[18];
   logic        r_iv;
   logic [31:0] r_id;

   initial begin
      // Streaming 1..8 at full throughput.
      for (int i = 0; i < 8; i++)
         vecs[i] = '{1'b1, 32'(i + 1), 1'b1, 1'b1, (i > 0), 32'(i)};
      vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8};
      vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0};
      // Backpressure into the skid register, then drain.
      vecs[10] = '{1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 32'h0};
      vecs[11] = '{1'b1, 32'hB, 1'b0, 1'b1, 1'b1, 32'hA};
      vecs[12] = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA};
      vecs[13] = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA};
      vecs[14] = '{1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hA};
      vecs[15] = '{1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 32'hB};
      vecs[16] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hC};
      vecs[17] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};

      // Reset held with a valid word presented.
      rst         = 1'b0;
      in_valid_i  = 1'b1;
      in_data_i   = 32'hDEAD_BEEF;
      out_ready_i = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rst_out_valid", 32'(out_valid_o), 32'h0);
         check("rst_out_data", out_data_o, 32'h0);
         check("rst_in_ready", 32'(in_ready_o), 32'h0);
      end
      @(posedge clk);
      #2;
      rst        = 1'b1;
      in_valid_i = 1'b0;
      model_reset();
      @(negedge clk);
      check("rel_in_ready", 32'(in_ready_o), 32'h1);
      check("rel_out_valid", 32'(out_valid_o), 32'h0);

      for (int i = 0; i < 18; i++) begin
         step(vecs[i].iv, vecs[i].id, vecs[i].ordy);
         check("vec_in_ready", 32'(s_ir), 32'(vecs[i].eir));
         check("vec_out_valid", 32'(s_ov), 32'(vecs[i].eov));
         if (vecs[i].eov) check("vec_out_data", s_od, vecs[i].eod);
      end

      // Random valid/ready; upstream keeps a pending word until accepted.
      r_iv = 1'b0;
      r_id = '0;
      last_in_fire = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         if (!r_iv || last_in_fire) begin
            r_iv = 1'($urandom_range(0, 1));
            r_id = $urandom;
         end
         step(r_iv, r_id, 1'($urandom_range(0, 1)));
      end
      repeat (3) step(1'b0, 32'h0, 1'b1);
      check("drain_empty", 32'(model_q.size()), 32'h0);

      // Asynchronous reset while full.
      step(1'b1, 32'h11, 1'b0);
      step(1'b1, 32'h22, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      check("full_in_ready", 32'(s_ir), 32'h0);
      check("full_out_data", s_od, 32'h11);
      #2;
      rst = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid_o), 32'h0);
      check("arst_in_ready", 32'(in_ready_o), 32'h0);
      check("arst_out_data", out_data_o, 32'h0);
      model_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      step(1'b1, 32'h33, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      check("post_rst_first", s_od, 32'h33);
      check("post_rst_valid", 32'(s_ov), 32'h1);
      step(1'b0, 32'h0, 1'b1);

`ifdef REG_SKID_STALL_CNT_EN
      step(1'b1, 32'h55, 1'b0);
      repeat (20) step(1'b0, 32'h0, 1'b0);
      check("stall_sat", 32'(stall_cnt_o), 32'(CNT_MAX));
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("stall_clr", 32'(stall_cnt_o), 32'h0);
      model_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      step(1'b0, 32'h0, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_reg_skid

// File: doc/reg_skid.md
Name: reg_skid

Overview:
- Elastic two-entry pipeline register (skid buffer) that forms the consuming end of a registered data stream.
- An upstream producer writes with valid/ready; a downstream stage reads with valid/ready.
- Decouples backpressure between pipeline stages so that in_ready_o is driven only from registered state.
- Sustains one transfer per cycle with 1-cycle latency.

Parameters:
- DWIDTH, 32, payload width in bits.
- CNT_W, 16, stall counter width; used only when REG_SKID_STALL_CNT_EN is defined.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid_i  input  1  upstream data valid.
- in_data_i  input  DWIDTH  upstream payload.
- in_ready_o  output  1  block can accept a word this cycle.
- out_valid_o  output  1  out_data_o holds a valid word.
- out_data_o  output  DWIDTH  downstream payload.
- out_ready_i  input  1  downstream accepts the word this cycle.
- stall_cnt_o  output  CNT_W  saturating stall count; present only with REG_SKID_STALL_CNT_EN.

Behaviour:
- Handshakes:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
- Storage: main register (drives out_data_o) and skid register; state in {S_EMPTY, S_ONE, S_FULL}.
- Reset (rst=0, asynchronous):
  - state=S_EMPTY, main=0, skid=0.
  - out_valid_o=0, out_data_o=0, stall_cnt_o=0.
  - in_ready_o=0 while rst=0.
- After reset release: in_ready_o = (state != S_FULL). It is a pure decode of registered state, with no combinational path from out_ready_i.
- out_valid_o = (state != S_EMPTY). out_data_o = main.
- S_EMPTY:
  - in_fire: main<=in_data_i, go to S_ONE.
  - Otherwise hold.
- S_ONE:
  - in_fire & out_fire: main<=in_data_i, stay in S_ONE (full throughput).
  - in_fire only: skid<=in_data_i, go to S_FULL.
  - out_fire only: go to S_EMPTY.
  - Neither: hold.
- S_FULL:
  - in_ready_o=0, so no input is accepted.
  - out_fire: main<=skid, go to S_ONE.
  - Otherwise hold.
- Latency: a word accepted in cycle N appears on out_data_o with out_valid_o=1 in cycle N+1.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Data stability: while out_valid_o=1 and out_ready_i=0, out_data_o is held stable.
- Protocol rules:
  - in_valid_i may be asserted without waiting for in_ready_o.
  - Upstream holds in_data_i stable until in_fire.
  - in_data_i is ignored when in_fire=0.
- Reset mid-operation: all buffered words are discarded; outputs return to reset values immediately (asynchronously).
- Skid register contents are don't-care outside S_FULL. The skid register does not need to be cleared on out_fire.

Optional Feature:
- Macro: REG_SKID_STALL_CNT_EN.
- Defined:
  - stall_cnt_o port exists.
  - Counter increments by 1 in every cycle where out_valid_o=1 and out_ready_i=0.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset.
- Undefined: no port and no counter logic; CNT_W is unused.

Decomposition:
- Package reg_skid_pkg:
  - typedef enum logic [1:0] skid_state_e {S_EMPTY=2'd0, S_ONE=2'd1, S_FULL=2'd2}.
  - Encoding 2'd3 is illegal; it recovers to S_EMPTY.
- Sub-module reg_en_arst:
  - DWIDTH-parameterised register with load enable and asynchronous active-low reset to 0.
  - Instantiated twice, for main and skid.
- FSM and handshake logic live in reg_skid.

Test Plan:
- Reset values: hold rst=0 for 3 cycles with in_valid_i=1 and in_data_i=32'hDEAD_BEEF. Check out_valid_o=0, out_data_o=0, in_ready_o=0. After release, in_ready_o=1 and out_valid_o=0.
- Full-throughput streaming: out_ready_i=1, push 0x1..0x8 back-to-back. Check out_data_o=0x1..0x8 on consecutive cycles starting one cycle after the first push, with in_ready_o=1 throughout.
- Backpressure and skid:
  - With out_ready_i=0, push 0xA then 0xB. Check state S_FULL, in_ready_o=0, and out_data_o=0xA stable.
  - Present 0xC (not accepted), then raise out_ready_i. Check output order 0xA, 0xB, 0xC with no loss.
- Random valid/ready: random in_valid_i and out_ready_i at 50% for 10k cycles. Scoreboard checks FIFO order, no drops or duplicates, and out_data_o stable while stalled.
- Asynchronous reset mid-operation: in S_FULL (0x11, 0x22), pulse rst=0 between clock edges. Check out_valid_o drops immediately, and after release the next pushed 0x33 is the first word out.
- REG_SKID_STALL_CNT_EN with CNT_W=4: hold out_valid_o=1 with out_ready_i=0 for 20 cycles. Check stall_cnt_o saturates at 15. Reset clears it to 0.
